// File: rtl/ram_arb.sv
// Two-port arbitrated byte-lane RAM: one grant per cycle with round-robin tie-break,
// a registered ack LATENCY cycles after each grant, and per-port read data registers.
module ram_arb #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_mem_en,
    input  logic                a_mem_write,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W/8-1:0] a_sel,
    input  logic [DATA_W-1:0]   a_data_in,
    output logic [DATA_W-1:0]   a_data_out,
    output logic                a_ack,
    input  logic                b_mem_en,
    input  logic                b_mem_write,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W/8-1:0] b_sel,
    input  logic [DATA_W-1:0]   b_data_in,
    output logic [DATA_W-1:0]   b_data_out,
    output logic                b_ack
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    if (!(LATENCY == 1 || LATENCY == 2)) begin : g_bad_latency
        $error("ram_arb: LATENCY must be 1 or 2");
    end
    if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_data_w
        $error("ram_arb: DATA_W must be a non-zero multiple of 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BUSY = 2'd2,
        ACK  = 2'd3
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            st_q    [2];
    logic [DATA_W-1:0] rd_q    [2];
    logic [DATA_W-1:0] stage_q [2];
    logic [1:0]        ack_q;
    logic [1:0]        is_rd_q;
    logic              prio_b_q;

    logic [1:0]        en_c;
    logic [1:0]        wr_c;
    logic [1:0]        elig_c;
    logic [1:0]        gnt_c;
    logic              gnt_port_c;
    logic              gnt_any_c;
    logic              g_wr_c;
    logic [ADDR_W-1:0] g_addr_c;
    logic [NB-1:0]     g_sel_c;
    logic [DATA_W-1:0] g_din_c;
    logic [DATA_W-1:0] rdata_c;

    assign en_c = {b_mem_en, a_mem_en};
    assign wr_c = {b_mem_write, a_mem_write};

    // A port competes only when it has nothing in flight and is not in its ack cycle.
    always_comb begin
        elig_c = '0;
        for (int p = 0; p < 2; p++) begin
            elig_c[p] = en_c[p] && (st_q[p] == IDLE || st_q[p] == WAIT);
        end
    end

    // Single grant per cycle; on a tie the port not granted most recently wins.
    always_comb begin
        gnt_c = '0;
        if (rst_n) begin
            if (elig_c[0] && elig_c[1]) begin
                if (prio_b_q) begin
                    gnt_c[1] = 1'b1;
                end else begin
                    gnt_c[0] = 1'b1;
                end
            end else begin
                gnt_c = elig_c;
            end
        end
    end

    assign gnt_port_c = gnt_c[1];
    assign gnt_any_c  = |gnt_c;
    assign g_wr_c     = gnt_port_c ? b_mem_write : a_mem_write;
    assign g_addr_c   = gnt_port_c ? b_addr      : a_addr;
    assign g_sel_c    = gnt_port_c ? b_sel       : a_sel;
    assign g_din_c    = gnt_port_c ? b_data_in   : a_data_in;
    assign rdata_c    = mem[g_addr_c];

    // Array is never reset; it is touched only at a grant edge.
    always_ff @(posedge clk) begin
        if (gnt_any_c && g_wr_c) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (g_sel_c[i]) begin
                    mem[g_addr_c][8*i +: 8] <= g_din_c[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b_q <= 1'b0;
        end else if (gnt_c[0]) begin
            prio_b_q <= 1'b1;
        end else if (gnt_c[1]) begin
            prio_b_q <= 1'b0;
        end
    end

    // Per-port request tracker; read data lands in rd_q exactly in the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                st_q[p]    <= IDLE;
                rd_q[p]    <= '0;
                stage_q[p] <= '0;
            end
            ack_q   <= '0;
            is_rd_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                ack_q[p] <= 1'b0;
                case (st_q[p])
                    IDLE, WAIT: begin
                        if (gnt_c[p]) begin
                            is_rd_q[p] <= !wr_c[p];
                            if (LATENCY == 1) begin
                                st_q[p]  <= ACK;
                                ack_q[p] <= 1'b1;
                                if (!wr_c[p]) begin
                                    rd_q[p] <= rdata_c;
                                end
                            end else begin
                                st_q[p] <= BUSY;
                                if (!wr_c[p]) begin
                                    stage_q[p] <= rdata_c;
                                end
                            end
                        end else begin
                            st_q[p] <= en_c[p] ? WAIT : IDLE;
                        end
                    end
                    BUSY: begin
                        st_q[p]  <= ACK;
                        ack_q[p] <= 1'b1;
                        if (is_rd_q[p]) begin
                            rd_q[p] <= stage_q[p];
                        end
                    end
                    ACK: begin
                        st_q[p] <= en_c[p] ? WAIT : IDLE;
                    end
                    default: begin
                        st_q[p] <= IDLE;
                    end
                endcase
            end
        end
    end

    assign a_ack      = ack_q[0];
    assign b_ack      = ack_q[1];
    assign a_data_out = rd_q[0];
    assign b_data_out = rd_q[1];

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb: one LATENCY=1 instance (a/b ports) and one LATENCY=2 instance (x/y ports).
module tb_ram_arb;

    logic        clk;
    logic        rst_n;

    logic        a_en, a_wr, b_en, b_wr;
    logic [7:0]  a_addr, b_addr;
    logic [3:0]  a_sel, b_sel;
    logic [31:0] a_din, b_din, a_dout, b_dout;
    logic        a_ack, b_ack;

    logic        x_en, x_wr, y_en, y_wr;
    logic [7:0]  x_addr, y_addr;
    logic [3:0]  x_sel, y_sel;
    logic [31:0] x_din, y_din, x_dout, y_dout;
    logic        x_ack, y_ack;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    ram_arb #(.ADDR_W(8), .DATA_W(32), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_mem_en(a_en), .a_mem_write(a_wr), .a_addr(a_addr), .a_sel(a_sel),
        .a_data_in(a_din), .a_data_out(a_dout), .a_ack(a_ack),
        .b_mem_en(b_en), .b_mem_write(b_wr), .b_addr(b_addr), .b_sel(b_sel),
        .b_data_in(b_din), .b_data_out(b_dout), .b_ack(b_ack)
    );

    ram_arb #(.ADDR_W(8), .DATA_W(32), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .a_mem_en(x_en), .a_mem_write(x_wr), .a_addr(x_addr), .a_sel(x_sel),
        .a_data_in(x_din), .a_data_out(x_dout), .a_ack(x_ack),
        .b_mem_en(y_en), .b_mem_write(y_wr), .b_addr(y_addr), .b_sel(y_sel),
        .b_data_in(y_din), .b_data_out(y_dout), .b_ack(y_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single uncontended access on the LATENCY=1 instance; rd is sampled in the ack cycle.
    task automatic acc(input logic port, input logic wr, input logic [7:0] addr,
                       input logic [3:0] sel, input logic [31:0] data,
                       input string tag, output logic [31:0] rdv);
        int   n;
        logic ack;
        if (!port) begin
            a_en = 1'b1; a_wr = wr; a_addr = addr; a_sel = sel; a_din = data;
        end else begin
            b_en = 1'b1; b_wr = wr; b_addr = addr; b_sel = sel; b_din = data;
        end
        n = 0;
        tick();
        ack = port ? b_ack : a_ack;
        while (!ack && n < 8) begin
            tick();
            n++;
            ack = port ? b_ack : a_ack;
        end
        rdv = port ? b_dout : a_dout;
        chk({tag, "_lat"}, 32'(n), 32'd0);
        if (!port) a_en = 1'b0; else b_en = 1'b0;
        tick();
        ack = port ? b_ack : a_ack;
        chk({tag, "_pulse"}, 32'(ack), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        a_en = 0; a_wr = 0; a_addr = 0; a_sel = 0; a_din = 0;
        b_en = 0; b_wr = 0; b_addr = 0; b_sel = 0; b_din = 0;
        x_en = 0; x_wr = 0; x_addr = 0; x_sel = 0; x_din = 0;
        y_en = 0; y_wr = 0; y_addr = 0; y_sel = 0; y_din = 0;
        tick();
        tick();
        chk("rst_a_ack", 32'(a_ack), 32'd0);
        chk("rst_b_ack", 32'(b_ack), 32'd0);
        chk("rst_a_dout", a_dout, 32'h0);
        chk("rst_b_dout", b_dout, 32'h0);
        chk("rst_x_dout", x_dout, 32'h0);
        rst_n = 1'b1;

        // Basic write then read on port A
        acc(1'b0, 1'b1, 8'h05, 4'hF, 32'hDEADBEEF, "a_wr05", rd);
        chk("a_dout_hold_wr", a_dout, 32'h0);
        acc(1'b0, 1'b0, 8'h05, 4'h0, 32'h0, "a_rd05", rd);
        chk("a_rd05_data", rd, 32'hDEADBEEF);

        // Byte-lane merge from port B over a full word from port A
        acc(1'b0, 1'b1, 8'h10, 4'hF, 32'h11223344, "a_wr10", rd);
        acc(1'b1, 1'b1, 8'h10, 4'b0101, 32'hAABBCCDD, "b_wr10", rd);
        acc(1'b1, 1'b0, 8'h10, 4'h0, 32'h0, "b_rd10", rd);
        chk("b_rd10_data", rd, 32'h11BB33DD);
        acc(1'b0, 1'b0, 8'h10, 4'hF, 32'h0, "a_rd10", rd);
        chk("a_rd10_data", rd, 32'h11BB33DD);

        // Last grant was A, so B wins this tie; A's one-cycle write request is withdrawn
        a_en = 1'b1; a_wr = 1'b1; a_addr = 8'h05; a_sel = 4'hF; a_din = 32'h0;
        b_en = 1'b1; b_wr = 1'b0; b_addr = 8'h05;
        tick();
        chk("tie_b_ack", 32'(b_ack), 32'd1);
        chk("tie_a_ack", 32'(a_ack), 32'd0);
        chk("tie_b_data", b_dout, 32'hDEADBEEF);
        a_en = 1'b0; b_en = 1'b0;
        tick();
        chk("wd_a_ack0", 32'(a_ack), 32'd0);
        tick();
        chk("wd_a_ack1", 32'(a_ack), 32'd0);
        acc(1'b0, 1'b0, 8'h05, 4'h0, 32'h0, "a_rd05b", rd);
        chk("wd_array_kept", rd, 32'hDEADBEEF);

        // Reset clears outputs but not the array; then both ports stream reads
        rst_n = 1'b0;
        #1;
        chk("rst2_a_dout", a_dout, 32'h0);
        chk("rst2_b_dout", b_dout, 32'h0);
        tick();
        rst_n = 1'b1;
        a_en = 1'b1; a_wr = 1'b0; a_addr = 8'h05;
        b_en = 1'b1; b_wr = 1'b0; b_addr = 8'h10;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("alt_a_ack%0d", i), 32'(a_ack), 32'((i % 2) == 0));
            chk($sformatf("alt_b_ack%0d", i), 32'(b_ack), 32'((i % 2) == 1));
            if ((i % 2) == 0) chk($sformatf("alt_a_data%0d", i), a_dout, 32'hDEADBEEF);
            else              chk($sformatf("alt_b_data%0d", i), b_dout, 32'h11BB33DD);
        end
        a_en = 1'b0; b_en = 1'b0;
        tick();
        tick();

        // LATENCY=2 instance: write then read 0x3F
        x_en = 1'b1; x_wr = 1'b1; x_addr = 8'h3F; x_sel = 4'hF; x_din = 32'hCAFEF00D;
        tick();
        chk("l2_wr_ack_g", 32'(x_ack), 32'd0);
        tick();
        chk("l2_wr_ack", 32'(x_ack), 32'd1);
        x_en = 1'b0;
        tick();
        chk("l2_wr_pulse", 32'(x_ack), 32'd0);
        x_en = 1'b1; x_wr = 1'b0;
        tick();
        chk("l2_rd_ack_g", 32'(x_ack), 32'd0);
        chk("l2_rd_hold", x_dout, 32'h0);
        tick();
        chk("l2_rd_ack", 32'(x_ack), 32'd1);
        chk("l2_rd_data", x_dout, 32'hCAFEF00D);
        x_en = 1'b0;
        tick();

        // Reset lands the cycle after a port-B read grant: that access is abandoned
        y_en = 1'b1; y_wr = 1'b0; y_addr = 8'h3F;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abandon_ack", 32'(y_ack), 32'd0);
        chk("abandon_dout", y_dout, 32'h0);
        y_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("abandon_ack1", 32'(y_ack), 32'd0);
        tick();
        chk("abandon_ack2", 32'(y_ack), 32'd0);
        chk("abandon_dout2", y_dout, 32'h0);

        // Both request after reset: A first, B one cycle later
        x_en = 1'b1; x_wr = 1'b0; x_addr = 8'h3F;
        y_en = 1'b1; y_wr = 1'b0; y_addr = 8'h3F;
        tick();
        chk("post_x_ack0", 32'(x_ack), 32'd0);
        chk("post_y_ack0", 32'(y_ack), 32'd0);
        tick();
        chk("post_x_ack1", 32'(x_ack), 32'd1);
        chk("post_x_data", x_dout, 32'hCAFEF00D);
        chk("post_y_ack1", 32'(y_ack), 32'd0);
        x_en = 1'b0;
        tick();
        chk("post_y_ack2", 32'(y_ack), 32'd1);
        chk("post_y_data", y_dout, 32'hCAFEF00D);
        chk("post_x_ack2", 32'(x_ack), 32'd0);
        y_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
